// File: rtl/calc_pkg.sv
// Shared constants for the calc op sequencer: opcodes, FSM states, widths.
// Imported by calc_op_sequencer and op_onehot_decoder.
package calc_pkg;

  localparam int ACC_W = 32;
  localparam int SEL_W = 16;
  localparam int OP_W  = 4;
  localparam int CNT_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL = 4'd5;
  localparam logic [OP_W-1:0] OP_DIV = 4'd6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

endpackage

// File: rtl/op_onehot_decoder.sv
// Combinational 4-bit opcode to 16-bit one-hot select.
// Ports: op (in, OP_W), onehot (out, SEL_W).
module op_onehot_decoder
  import calc_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] onehot
);

  always_comb begin
    onehot     = '0;
    onehot[op] = 1'b1;
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Command sequencer driving a 16-way one-hot result mux into an accumulator.
// Ports: clk, rst_n, cmd_valid/ready/op/clr, hotselect, muxout, err_in,
// acc, done, err. Option: CALC_ERR_EN enables err_in gating and sticky err.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int               MULTI_LAT  = 8,
  parameter logic [SEL_W-1:0] MULTI_MASK = 16'h0060,
  parameter logic [ACC_W-1:0] ACC_INIT   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_clr,
  output logic [SEL_W-1:0] hotselect,
  input  logic [ACC_W-1:0] muxout,
  input  logic [SEL_W-1:0] err_in,
  output logic [ACC_W-1:0] acc,
  output logic             done,
  output logic             err
);

  logic [1:0]       state;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] dec;
  logic             accept;
  logic             cap_ok;

  op_onehot_decoder u_dec (
    .op     (cmd_op),
    .onehot (dec)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

`ifdef CALC_ERR_EN
  assign cap_ok = ~err_in[op_q];
`else
  logic unused_err_in;
  assign unused_err_in = ^err_in;
  assign cap_ok        = 1'b1;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      cnt       <= '0;
      hotselect <= '0;
      acc       <= ACC_INIT;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            if (cmd_clr) begin
              acc  <= ACC_INIT;
              done <= 1'b1;
            end else begin
              // select goes out with SELECT so the mux settles early
              hotselect <= dec;
              state     <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          if (MULTI_MASK[op_q]) begin
            cnt   <= CNT_W'(MULTI_LAT - 1);
            state <= ST_WAIT;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_CAPTURE: begin
          if (cap_ok) acc <= muxout;
          done      <= 1'b1;
          hotselect <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == ST_IDLE && accept && cmd_clr) begin
      err <= 1'b0;
    end else if (state == ST_CAPTURE && !cap_ok) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
